// File: rtl/lpm_fifo_pkg.sv
// Shared helpers and mode constants for the lpm FIFO family.
package lpm_fifo_pkg;

  // Values for the PIPELINED parameter of fifo_n.
  localparam int unsigned FIFO_NORMAL = 0;
  localparam int unsigned FIFO_PIPE   = 1;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Wrap-safe pointer increment; explicit compare so non-power-of-two
  // depths wrap at depth-1 instead of at the natural bit-width overflow.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_n.sv
// Parametrised multi-entry FIFO with occupancy count, synchronous clear
// and an optional pipelined mode (enqueue accepted while full if a dequeue
// fires in the same cycle). No same-cycle bypass from enq to first.
module fifo_n
  import lpm_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PIPELINED = FIFO_NORMAL,
  parameter int unsigned CW        = clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             clear__ENA,
  output logic             clear__RDY,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic not_empty;
  logic not_full;
  logic enq_rdy;
  logic enq_fire;
  logic deq_fire;

  // Handshake readiness and effective fires; in pipelined mode deq_ENA
  // feeds enq_RDY combinationally.
  always_comb begin
    not_empty = (cnt_q != '0);
    not_full  = (cnt_q != CW'(DEPTH));
    if (PIPELINED == FIFO_PIPE) enq_rdy = not_full | (out_deq__ENA & not_empty);
    else                        enq_rdy = not_full;
    enq_fire = in_enq__ENA & enq_rdy;
    deq_fire = out_deq__ENA & not_empty;
  end

  // Output drive: head is whatever sits at rd_ptr, valid only while non-empty.
  always_comb begin
    in_enq__RDY    = enq_rdy;
    out_deq__RDY   = not_empty;
    out_first__RDY = not_empty;
    out_first      = mem_q[rd_ptr_q];
    clear__RDY     = 1'b1;
    count          = cnt_q;
  end

  // Next-state pointers and count; clear discards same-cycle enq/deq.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear__ENA) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_fire) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (deq_fire) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
      unique case ({enq_fire, deq_fire})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage: zeroed on reset, written on an enqueue fire; clear leaves data
  // in place. When full and pipelined, the overwrite lands after the head read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire && !clear__ENA) begin
      mem_q[wr_ptr_q] <= in_enq_v;
    end
  end

endmodule

// File: tb/tb_fifo_n.sv
// Bench for fifo_n: three instances (DEPTH 4 normal, DEPTH 4 pipelined,
// DEPTH 3 normal) against a queue-based reference model.
module tb_fifo_n;
  import lpm_fifo_pkg::*;

  localparam int unsigned W = 128;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic         enq_ena   [3];
  logic [W-1:0] enq_v     [3];
  logic         deq_ena   [3];
  logic         clr       [3];
  logic         enq_rdy   [3];
  logic         deq_rdy   [3];
  logic         first_rdy [3];
  logic         clr_rdy   [3];
  logic [W-1:0] first     [3];
  logic [2:0]   cnt_a, cnt_b;
  logic [1:0]   cnt_c;

  fifo_n #(.WIDTH(W), .DEPTH(4), .PIPELINED(FIFO_NORMAL)) u_n4 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(enq_ena[0]), .in_enq_v(enq_v[0]), .in_enq__RDY(enq_rdy[0]),
    .out_deq__ENA(deq_ena[0]), .out_deq__RDY(deq_rdy[0]),
    .out_first(first[0]), .out_first__RDY(first_rdy[0]),
    .clear__ENA(clr[0]), .clear__RDY(clr_rdy[0]), .count(cnt_a)
  );

  fifo_n #(.WIDTH(W), .DEPTH(4), .PIPELINED(FIFO_PIPE)) u_p4 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(enq_ena[1]), .in_enq_v(enq_v[1]), .in_enq__RDY(enq_rdy[1]),
    .out_deq__ENA(deq_ena[1]), .out_deq__RDY(deq_rdy[1]),
    .out_first(first[1]), .out_first__RDY(first_rdy[1]),
    .clear__ENA(clr[1]), .clear__RDY(clr_rdy[1]), .count(cnt_b)
  );

  fifo_n #(.WIDTH(W), .DEPTH(3), .PIPELINED(FIFO_NORMAL)) u_n3 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(enq_ena[2]), .in_enq_v(enq_v[2]), .in_enq__RDY(enq_rdy[2]),
    .out_deq__ENA(deq_ena[2]), .out_deq__RDY(deq_rdy[2]),
    .out_first(first[2]), .out_first__RDY(first_rdy[2]),
    .clear__ENA(clr[2]), .clear__RDY(clr_rdy[2]), .count(cnt_c)
  );

  // Reference model: one queue per instance.
  logic [W-1:0] mq [3][$];
  int unsigned  md [3] = '{4, 4, 3};
  bit           mp [3] = '{1'b0, 1'b1, 1'b0};

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int lane,
                     input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s lane%0d: observed %0h expected %0h", tag, lane, obs, exp);
    end
  endtask

  function automatic int ptrdiff(input int wr, input int rd, input int d);
    return (wr - rd + d) % d;
  endfunction

  task automatic set(input int l, input logic e, input logic [W-1:0] v,
                     input logic d, input logic c);
    enq_ena[l] = e;
    enq_v[l]   = v;
    deq_ena[l] = d;
    clr[l]     = c;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) set(i, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Check all outputs against the model with current inputs applied,
  // then advance one clock and update the model.
  task automatic cycle();
    bit          ef [3];
    bit          df [3];
    logic [2:0]  cnt_o [3];
    int unsigned sz;
    logic        erdy;
    #3;
    cnt_o[0] = cnt_a;
    cnt_o[1] = cnt_b;
    cnt_o[2] = {1'b0, cnt_c};
    for (int i = 0; i < 3; i++) begin
      sz   = mq[i].size();
      erdy = (sz != md[i]) || (mp[i] && deq_ena[i] && (sz != 0));
      chk("count", i, W'(cnt_o[i]), W'(sz));
      chk("count_le_depth", i, W'(32'(cnt_o[i]) <= md[i]), W'(1));
      chk("enq_rdy", i, W'(enq_rdy[i]), W'(erdy));
      chk("deq_rdy", i, W'(deq_rdy[i]), W'(sz != 0));
      chk("first_rdy", i, W'(first_rdy[i]), W'(sz != 0));
      chk("clear_rdy", i, W'(clr_rdy[i]), W'(1));
      if (sz != 0) chk("first", i, first[i], mq[i][0]);
      ef[i] = enq_ena[i] && erdy;
      df[i] = deq_ena[i] && (sz != 0);
    end
    chk("ptr_rel", 0, W'(ptrdiff(int'(u_n4.wr_ptr_q), int'(u_n4.rd_ptr_q), 4)),
        W'(mq[0].size() % 4));
    chk("ptr_rel", 1, W'(ptrdiff(int'(u_p4.wr_ptr_q), int'(u_p4.rd_ptr_q), 4)),
        W'(mq[1].size() % 4));
    chk("ptr_rel", 2, W'(ptrdiff(int'(u_n3.wr_ptr_q), int'(u_n3.rd_ptr_q), 3)),
        W'(mq[2].size() % 3));
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (RST || clr[i]) begin
        mq[i].delete();
      end else begin
        if (df[i]) mq[i].delete(0);
        if (ef[i]) mq[i].push_back(enq_v[i]);
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    idle();
    @(posedge CLK);
    #1;
    cycle();
    RST = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) chk("first_after_reset", i, first[i], '0);

    // Fill both DEPTH=4 instances with 0x11..0x44, then try 0x55.
    for (int k = 1; k <= 4; k++) begin
      idle();
      set(0, 1'b1, W'(k * 'h11), 1'b0, 1'b0);
      set(1, 1'b1, W'(k * 'h11), 1'b0, 1'b0);
      cycle();
    end
    idle();
    set(0, 1'b1, W'('h55), 1'b0, 1'b0);
    set(1, 1'b1, W'('h55), 1'b0, 1'b0);
    cycle();
    chk("full_count", 0, W'(cnt_a), W'(4));
    chk("full_first", 0, first[0], W'('h11));

    // enq 0x99 + deq while full: both fire only when pipelined.
    idle();
    set(0, 1'b1, W'('h99), 1'b1, 1'b0);
    set(1, 1'b1, W'('h99), 1'b1, 1'b0);
    cycle();
    chk("nopipe_count", 0, W'(cnt_a), W'(3));
    chk("pipe_count", 1, W'(cnt_b), W'(4));
    for (int k = 0; k < 4; k++) begin
      idle();
      set(0, 1'b0, '0, 1'b1, 1'b0);
      set(1, 1'b0, '0, 1'b1, 1'b0);
      cycle();
    end
    chk("drained", 0, W'(cnt_a), W'(0));
    chk("drained", 1, W'(cnt_b), W'(0));

    // DEPTH=3 wrap: 10 enq/deq pairs.
    for (int k = 0; k < 10; k++) begin
      idle();
      set(2, 1'b1, W'(k), 1'b0, 1'b0);
      cycle();
      chk("wrap_first", 2, first[2], W'(k));
      idle();
      set(2, 1'b0, '0, 1'b1, 1'b0);
      cycle();
    end

    // Simultaneous enq(0xAA) + deq at count 2.
    idle(); set(0, 1'b1, W'('hA1), 1'b0, 1'b0); cycle();
    idle(); set(0, 1'b1, W'('hA2), 1'b0, 1'b0); cycle();
    idle(); set(0, 1'b1, W'('hAA), 1'b1, 1'b0); cycle();
    chk("simul_count", 0, W'(cnt_a), W'(2));
    chk("simul_first", 0, first[0], W'('hA2));
    for (int k = 0; k < 2; k++) begin
      idle(); set(0, 1'b0, '0, 1'b1, 1'b0); cycle();
    end

    // Clear with enq(0x77) at count 3.
    for (int k = 1; k <= 3; k++) begin
      idle(); set(0, 1'b1, W'('hC0 + k), 1'b0, 1'b0); cycle();
    end
    idle(); set(0, 1'b1, W'('h77), 1'b0, 1'b1); cycle();
    chk("clear_count", 0, W'(cnt_a), W'(0));
    chk("clear_first_rdy", 0, W'(first_rdy[0]), W'(0));
    idle(); set(0, 1'b1, W'('h88), 1'b0, 1'b0); cycle();
    chk("after_clear_first", 0, first[0], W'('h88));
    idle(); set(0, 1'b0, '0, 1'b1, 1'b0); cycle();

    // Reset mid-operation.
    for (int k = 0; k < 2; k++) begin
      idle();
      for (int i = 0; i < 3; i++) set(i, 1'b1, W'('hE0 + k), 1'b0, 1'b0);
      cycle();
    end
    idle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    chk("rst_count", 0, W'(cnt_a), W'(0));
    chk("rst_count", 1, W'(cnt_b), W'(0));
    chk("rst_count", 2, W'(cnt_c), W'(0));

    // Randomized traffic: enqueue-heavy then dequeue-heavy.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        set(i,
            (n < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0));
      end
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
